// File: rtl/violation_logger_if.sv
// Log RAM write port: one write strobe, address and record per logged event.
interface violation_logger_if #(
  parameter int DEPTH_LOG2 = 16,
  parameter int REC_W      = 55
);
  logic                  we;
  logic [DEPTH_LOG2-1:0] wr_addr;
  logic [REC_W-1:0]      wr_data;

  modport master (output we, wr_addr, wr_data);
  modport slave  (input  we, wr_addr, wr_data);
endinterface

// File: rtl/violation_logger.sv
// Violation event logger: edge-detects NUM_SRC reset sources, queues them per source
// and writes one timestamped record per cycle into an external log RAM.

// Per-source slot: pending flag plus the snapshot taken at the first edge.
module vl_src_slot #(
  parameter int SNAP_W = 50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              cap,
  input  logic              gnt,
  input  logic [SNAP_W-1:0] snap_in,
  output logic              pending,
  output logic [SNAP_W-1:0] snap
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
      snap    <= '0;
    end else if (clr) begin
      pending <= 1'b0;
    end else if (cap) begin
      pending <= 1'b1;
      snap    <= snap_in;
    end else if (gnt) begin
      pending <= 1'b0;
    end
  end
endmodule

module violation_logger #(
  parameter int                 NUM_SRC    = 6,
  parameter logic [NUM_SRC-1:0] DMA_MASK   = 6'h38,
  parameter int                 DEPTH_LOG2 = 16,
  parameter int                 TS_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_SRC-1:0]    src_viol,
  input  logic                  log_en,
  input  logic                  stop_on_full,
  input  logic                  clr,
  input  logic [15:0]           pc,
  input  logic [15:0]           data_addr,
  input  logic                  data_en,
  input  logic                  data_wr,
  input  logic [15:0]           dma_addr,
  input  logic                  dma_en,
  violation_logger_if.master    log_wr,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  wrapped,
  output logic [15:0]           drop_cnt
);
  localparam int SNAP_W = TS_W + 34;
  localparam int REC_W  = 3 + TS_W + 36;
  localparam int CNT_W  = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [TS_W-1:0]                 ts;
  logic                            armed;
  logic [NUM_SRC-1:0]              src_prev, edge_v, cap, coal, pending, gnt;
  logic [NUM_SRC-1:0][SNAP_W-1:0]  snap;
  logic [SNAP_W-1:0]               gnt_snap;
  logic [2:0]                      gnt_idx;
  logic                            any_gnt, drop_full;
  logic [3:0]                      drop_inc;
  logic [16:0]                     drop_sum;
  logic [DEPTH_LOG2-1:0]           wptr;
  logic [CNT_W-1:0]                count_inc;
  logic                            we_q;
  logic [DEPTH_LOG2-1:0]           wr_addr_q;
  logic [REC_W-1:0]                wr_data_q;

  // armed suppresses edges on the first cycle after reset, so a level already
  // high when reset drops is treated as old, not as a new violation.
  always_comb begin
    edge_v = src_viol & ~src_prev & {NUM_SRC{log_en & armed}};
    cap    = edge_v & ~pending;
    coal   = edge_v & pending;
  end

  // Fixed priority: lowest index wins, using the pending vector before this cycle's captures.
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    gnt_snap = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending[i]) begin
        gnt      = '0;
        gnt[i]   = 1'b1;
        gnt_idx  = 3'(i);
        gnt_snap = snap[i];
      end
    end
  end

  always_comb begin
    any_gnt   = |pending;
    drop_full = any_gnt & full & stop_on_full;
    drop_inc  = {3'b0, drop_full};
    for (int i = 0; i < NUM_SRC; i++) drop_inc = drop_inc + {3'b0, coal[i]};
    drop_sum  = {1'b0, drop_cnt} + {13'b0, drop_inc};
    count_inc = count + CNT_W'(1);
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [SNAP_W-1:0] snap_in;
    if (DMA_MASK[i]) begin : g_dma
      assign snap_in = {ts, pc, dma_addr, dma_en, 1'b0};
    end else begin : g_cpu
      assign snap_in = {ts, pc, data_addr, data_en, data_wr};
    end
    vl_src_slot #(.SNAP_W(SNAP_W)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .cap     (cap[i]),
      .gnt     (gnt[i]),
      .snap_in (snap_in),
      .pending (pending[i]),
      .snap    (snap[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts        <= '0;
      armed     <= 1'b0;
      src_prev  <= '0;
      wptr      <= '0;
      count     <= '0;
      full      <= 1'b0;
      wrapped   <= 1'b0;
      drop_cnt  <= '0;
      we_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      ts       <= ts + TS_W'(1);
      armed    <= 1'b1;
      src_prev <= src_viol;
      if (clr) begin
        wptr     <= '0;
        count    <= '0;
        full     <= 1'b0;
        wrapped  <= 1'b0;
        drop_cnt <= '0;
        we_q     <= 1'b0;
      end else begin
        we_q     <= 1'b0;
        drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        if (any_gnt && !drop_full) begin
          we_q      <= 1'b1;
          wr_addr_q <= wptr;
          // Two zero pad bits sit above the code field to fill the record width.
          wr_data_q <= {2'b00, gnt_idx + 3'd1, gnt_snap};
          wptr      <= wptr + DEPTH_LOG2'(1);
          if (full) begin
            wrapped <= 1'b1;
          end else begin
            count <= count_inc;
            full  <= (count_inc == CNT_MAX);
          end
        end
      end
    end
  end

  assign log_wr.we      = we_q;
  assign log_wr.wr_addr = wr_addr_q;
  assign log_wr.wr_data = wr_data_q;
endmodule

// File: tb/tb_violation_logger.sv
// Scoreboard bench for violation_logger with a 4-entry log so full/wrap paths are reachable.
module tb_violation_logger;
  localparam int NS = 6, DL = 2, TW = 16, RW = 3 + TW + 36;

  typedef struct {
    logic [DL-1:0] addr;
    logic [RW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NS-1:0] src_viol = '0;
  logic          log_en = 1'b1, stop_on_full = 1'b0, clr = 1'b0;
  logic [15:0]   pc = '0, data_addr = '0, dma_addr = '0;
  logic          data_en = 1'b0, data_wr = 1'b0, dma_en = 1'b0;
  logic [DL:0]   count;
  logic          full, wrapped;
  logic [15:0]   drop_cnt;
  logic [TW-1:0] m_ts;

  exp_t q[$];
  int   checks = 0, fails = 0, exp_wptr = 0;

  always #5 clk = ~clk;

  violation_logger_if #(.DEPTH_LOG2(DL), .REC_W(RW)) lw ();

  violation_logger #(.NUM_SRC(NS), .DMA_MASK(6'h38), .DEPTH_LOG2(DL), .TS_W(TW)) dut (
    .clk(clk), .rst(rst), .src_viol(src_viol), .log_en(log_en), .stop_on_full(stop_on_full),
    .clr(clr), .pc(pc), .data_addr(data_addr), .data_en(data_en), .data_wr(data_wr),
    .dma_addr(dma_addr), .dma_en(dma_en), .log_wr(lw), .count(count), .full(full),
    .wrapped(wrapped), .drop_cnt(drop_cnt)
  );

  // Reference free-running timestamp.
  always @(posedge clk or posedge rst)
    if (rst) m_ts <= '0;
    else     m_ts <= m_ts + 16'd1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Sources 3..5 record the DMA bus (mask 0x38), others the CPU bus.
  function automatic logic [RW-1:0] mk_rec(input int src);
    if (src >= 3) return {2'b00, 3'(src + 1), m_ts, pc, dma_addr, dma_en, 1'b0};
    else          return {2'b00, 3'(src + 1), m_ts, pc, data_addr, data_en, data_wr};
  endfunction

  task automatic push(input int src);
    exp_t e;
    e.addr = 2'(exp_wptr);
    e.data = mk_rec(src);
    q.push_back(e);
    exp_wptr = (exp_wptr + 1) % 4;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    exp_wptr = 0;
  endtask

  task automatic pulse_one(input logic expect_write);
    src_viol = 6'b000001;
    if (expect_write) push(0);
    tick(1);
    src_viol = '0;
    tick(2);
  endtask

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (lw.we) begin
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_write addr=%0h data=%0h", lw.wr_addr, lw.wr_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wr_addr", 64'(lw.wr_addr), 64'(e.addr));
        chk("wr_data", 64'(lw.wr_data), 64'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    tick(3);
    chk("rst_we", 64'(lw.we), 64'd0);
    chk("rst_wr_addr", 64'(lw.wr_addr), 64'd0);
    chk("rst_wr_data", 64'(lw.wr_data), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_wrapped", 64'(wrapped), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    rst = 1'b0;
    tick(3);

    // Single CPU pulse, with latency check: we rises one edge after capture.
    pc = 16'h1234; data_addr = 16'hA000; data_en = 1'b1; data_wr = 1'b1;
    dma_addr = 16'hBEEF; dma_en = 1'b1;
    src_viol = 6'b000001;
    push(0);
    tick(1);
    src_viol = '0;
    chk("lat_we_capture", 64'(lw.we), 64'd0);
    tick(1);
    chk("lat_we_grant", 64'(lw.we), 64'd1);
    tick(2);
    chk("t1_count", 64'(count), 64'd1);

    // Three simultaneous edges drain in priority order; code 6 is DMA.
    clr_pulse();
    pc = 16'h2222; data_addr = 16'h0F0F;
    src_viol = 6'b100101;
    push(0); push(2); push(5);
    tick(1);
    src_viol = '0;
    tick(4);
    chk("t2_count", 64'(count), 64'd3);

    // Level held high logs once.
    clr_pulse();
    src_viol = 6'b000100;
    push(2);
    tick(50);
    src_viol = '0;
    tick(3);
    chk("t3_hold_count", 64'(count), 64'd1);
    chk("t3_hold_drop", 64'(drop_cnt), 64'd0);

    // Re-edge on a still-pending source coalesces and keeps the first snapshot.
    clr_pulse();
    pc = 16'h3333;
    src_viol = 6'b000111;
    push(0); push(1); push(2);
    tick(1);
    src_viol = '0;
    tick(1);
    src_viol = 6'b000100; pc = 16'h5555;
    tick(1);
    src_viol = '0;
    tick(3);
    chk("t3_coal_drop", 64'(drop_cnt), 64'd1);
    chk("t3_coal_count", 64'(count), 64'd3);

    // Stop mode: 6 events into 4 entries.
    clr_pulse();
    stop_on_full = 1'b1;
    for (int n = 0; n < 6; n++) pulse_one(n < 4);
    tick(2);
    chk("stop_count", 64'(count), 64'd4);
    chk("stop_full", 64'(full), 64'd1);
    chk("stop_drop", 64'(drop_cnt), 64'd2);
    chk("stop_wrapped", 64'(wrapped), 64'd0);

    // Wrap mode: addresses 0,1,2,3,0,1.
    clr_pulse();
    stop_on_full = 1'b0;
    for (int n = 0; n < 6; n++) pulse_one(1'b1);
    tick(2);
    chk("wrap_count", 64'(count), 64'd4);
    chk("wrap_full", 64'(full), 64'd1);
    chk("wrap_wrapped", 64'(wrapped), 64'd1);
    chk("wrap_drop", 64'(drop_cnt), 64'd0);

    // clr while an event is pending: no write, pointer restarts.
    clr_pulse();
    src_viol = 6'b000001;
    tick(1);
    src_viol = '0;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(3);
    chk("clr_count", 64'(count), 64'd0);
    chk("clr_full", 64'(full), 64'd0);
    src_viol = 6'b000010;
    push(1);
    tick(1);
    src_viol = '0;
    tick(3);
    chk("clr_after_count", 64'(count), 64'd1);

    // Async reset mid-drain; held levels must not relog after release.
    clr_pulse();
    src_viol = 6'b000111;
    push(0);
    tick(2);
    #2 rst = 1'b1;
    exp_wptr = 0;
    #1;
    chk("arst_we", 64'(lw.we), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    tick(2);
    rst = 1'b0;
    tick(6);
    chk("arst_held_count", 64'(count), 64'd0);
    src_viol = '0;
    tick(2);
    src_viol = 6'b000010;
    push(1);
    tick(1);
    src_viol = '0;
    tick(3);
    chk("arst_relog_count", 64'(count), 64'd1);

    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
